// File: rtl/mem_burst_responder.sv
// Memory-side burst-read responder backed by a preloadable word RAM.
// Returns power-of-two aligned bursts after a fixed request-to-data latency.
module mem_burst_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2,
    parameter int MAXBURST   = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           mem_rdaddr,
    input  logic                  mem_rdreq,
    input  logic [15:0]           mem_burstlen,
    output logic [31:0]           mem_dataout,
    output logic                  mem_datavalid,
    output logic                  busy,
    output logic                  req_err,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    input  logic                  ld_we
);

    localparam int              CNT_W     = $clog2(MAXBURST) + 1;
    localparam logic [3:0]      WAIT_LOAD = 4'(LATENCY - 1);
    localparam logic [16:0]     MAXB      = 17'(MAXBURST);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wait_q, wait_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        lenm1_q, lenm1_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    valid_q;
    logic [31:0]             dout_q;

    logic [31:0]             ram [2**DEPTH_LOG2];

    logic                    rd_en;
    logic                    busy_c;
    logic                    accept;
    logic                    bl_legal;
    logic [DEPTH_LOG2-1:0]   req_widx;
    logic [DEPTH_LOG2-1:0]   req_base;
    logic                    unused_addr;

    assign unused_addr = ^{mem_rdaddr[31:DEPTH_LOG2+2], mem_rdaddr[1:0]};

    assign req_widx = mem_rdaddr[DEPTH_LOG2+1:2];
    // Truncating burstlen to RAM width makes a full-depth burst align to word 0.
    assign req_base = req_widx & ~(DEPTH_LOG2'(mem_burstlen) - DEPTH_LOG2'(1));
    assign bl_legal = (mem_burstlen != 16'd0)
                   && ((mem_burstlen & (mem_burstlen - 16'd1)) == 16'd0)
                   && ({1'b0, mem_burstlen} <= MAXB);

    // State and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cnt_q   <= '0;
            lenm1_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            lenm1_q <= lenm1_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            valid_q <= rd_en;
            if (rd_en) begin
                dout_q <= ram[addr_q];
            end
        end
    end

    // Preload port; reads in the same edge see the previous contents.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            ram[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        lenm1_d = lenm1_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bl_legal) begin
                        addr_d  = req_base;
                        lenm1_d = CNT_W'(mem_burstlen - 16'd1);
                        cnt_d   = '0;
                        wait_d  = WAIT_LOAD;
                        state_d = (LATENCY == 1) ? S_BURST : S_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                wait_d = wait_q - 4'd1;
                if (wait_d == 4'd0) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                addr_d = addr_q + DEPTH_LOG2'(1);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == lenm1_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // busy covers the final data cycle, after the FSM has already returned to idle.
    always_comb begin
        rd_en  = (state_q == S_BURST);
        busy_c = (state_q != S_IDLE) || valid_q;
        accept = mem_rdreq && !busy_c;
    end

    assign busy          = busy_c;
    assign mem_datavalid = valid_q;
    assign mem_dataout   = dout_q;
    assign req_err       = err_q;

endmodule

// File: doc/mem_burst_responder.md
Name: mem_burst_responder

Overview:
- Synthesizable memory-side responder for the cache burst-read interface: the cache drives mem_rdaddr/mem_rdreq/mem_burstlen, and this block returns the burst on mem_dataout/mem_datavalid.
- Backed by an internal word-wide RAM that a side port preloads.
- Used as the on-chip boot/instruction memory behind icache and as a timing-accurate replacement for behavioural memory models in simulation.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- LATENCY, 2, cycles from request acceptance to first valid data word; legal range 1..15.
- MAXBURST, 64, largest accepted burst length in words; must be a power of two.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- mem_rdaddr  in  32  byte address of requested word; bits [1:0] ignored
- mem_rdreq  in  1  single-cycle read request strobe
- mem_burstlen  in  16  burst length in words, sampled with mem_rdreq
- mem_dataout  out  32  burst data word
- mem_datavalid  out  1  mem_dataout valid this cycle
- busy  out  1  request in progress; new requests ignored
- req_err  out  1  one-cycle pulse: request rejected
- ld_addr  in  DEPTH_LOG2  preload word address
- ld_data  in  32  preload data
- ld_we  in  1  preload write enable

Behaviour:
- Reset (asynchronous): mem_dataout=0, mem_datavalid=0, busy=0, req_err=0, state=IDLE, counters=0. RAM contents are not reset.
- Word index: widx = mem_rdaddr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so the RAM aliases across the address space.
- Legal burstlen: a power of two, 1..MAXBURST.
- Illegal burstlen (0, non-power-of-two, >MAXBURST) in IDLE:
  - req_err pulses for one cycle after the sampling edge.
  - State stays IDLE and no data is returned.
- Alignment: the base address is widx with its low log2(burstlen) bits cleared. Words are returned linearly: base, base+1, ..., base+burstlen-1 (critical word is not returned first).
- RAM address arithmetic is modulo 2^DEPTH_LOG2. Wrap from the top word to word 0 is only possible when burstlen equals the RAM depth; alignment prevents it otherwise.
- FSM:
  - IDLE: mem_rdreq with a legal burstlen at edge E0 latches base and burstlen, sets busy=1, loads the wait counter with LATENCY-1, and moves to WAIT (or directly to BURST if LATENCY=1).
  - WAIT: decrement the counter; at 0, move to BURST.
  - BURST: each cycle issues a RAM read at the current address and increments the address and word count. After the last word is issued, move to IDLE.
- Timing:
  - The RAM read is synchronous and mem_dataout is registered.
  - The first mem_datavalid=1 occurs in the cycle after edge E0+LATENCY.
  - mem_datavalid stays high for exactly burstlen consecutive cycles with no gaps, then drops to 0.
  - busy drops in the same cycle mem_datavalid drops, so a new request is accepted at the first edge where mem_datavalid=0.
- mem_dataout holds its last value when mem_datavalid=0; consumers must qualify it with mem_datavalid.
- Requests while busy=1 are silently dropped: not queued, no req_err. mem_burstlen is sampled only at acceptance.
- Preload port is always active, including during a burst:
  - A write at edge N is visible to any RAM read issued at edge N+1 or later.
  - A same-edge read/write collision on one address returns the old data.
- Reset mid-burst: mem_datavalid and busy drop immediately (asynchronously); the remaining words are discarded. The first request after reset release behaves as from IDLE.
- Widths: word counter is log2(MAXBURST)+1 bits; wait counter is 4 bits.

Test Plan:
- Reset values: assert reset_n=0 mid-simulation -> mem_datavalid=0, busy=0, req_err=0, mem_dataout=0 with no clock edge required.
- Basic burst:
  - Stimulus: preload word i = 0xA5000000+i for i=0..1023; LATENCY=2; request rdaddr=0x00000000, burstlen=32.
  - Required response: mem_datavalid first high in the cycle after the 2nd edge following acceptance; 32 contiguous words 0xA5000000..0xA500001F; then mem_datavalid=0 and busy=0.
- Alignment and aliasing:
  - rdaddr=0x00000084, burstlen=32 -> words 0xA5000020..0xA500003F.
  - rdaddr=0x20000FFC, burstlen=4 -> words 0xA50003FC..0xA50003FF (upper address bits ignored).
- Busy and errors:
  - Second mem_rdreq (rdaddr=0x40) during an active burst -> ignored, no req_err, exactly one burst returned.
  - burstlen=0, 3, 128 -> req_err pulse each time, mem_datavalid never asserted.
- Preload during burst: during a burst from 0x0, write ld_addr=20, ld_data=0xDEADBEEF two cycles before word 20 is issued -> word 20 returned as 0xDEADBEEF; all other words unchanged.
- Reset mid-burst: pull reset_n low after 10 data words -> mem_datavalid=0 immediately. After release, request rdaddr=0x0, burstlen=8 -> 8 correct words with normal latency.
